// File: rtl/branch_flag_generator.sv
`default_nettype none
// ============================================================================
// Module   : branch_flag_generator
// Function : Digit-serial rs1 - rs2 comparator producing Z/C/V/N branch flags.
// Revision : 1.0 - initial release
// ============================================================================
module branch_flag_generator #(
  parameter int XLEN    = 32,
  parameter int CHUNK_W = 8
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            flush,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [XLEN-1:0] operand_a,
  input  logic [XLEN-1:0] operand_b,
  input  logic [2:0]      funct3_in,
  output logic            out_valid,
  input  logic            out_ready,
  output logic            zero_flag,
  output logic            carry_flag,
  output logic            overflow_flag,
  output logic            sign_flag,
  output logic [2:0]      funct3_out
);

  localparam int NCHUNK = XLEN / CHUNK_W;
  localparam int CNT_W  = (NCHUNK > 1) ? $clog2(NCHUNK) : 1;
  localparam logic [CNT_W-1:0] C_LAST = CNT_W'(NCHUNK - 1);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_CALC = 2'd1,
    S_DONE = 2'd2
  } state_t;

  state_t             r_state;
  state_t             w_state_nxt;
  logic [XLEN-1:0]    r_a;
  logic [XLEN-1:0]    r_b;
  logic [CNT_W-1:0]   r_cnt;
  logic               r_carry_acc;
  logic               r_zero_acc;
  logic               r_zero;
  logic               r_carry;
  logic               r_ovf;
  logic               r_sign;
  logic [2:0]         r_funct3;

  logic               w_accept;
  logic               w_last;
  logic [CHUNK_W:0]   w_sum;
  logic               w_chunk_zero;
  logic               w_sign;
  logic               w_ovf;

  // Operands shift right each CALC cycle, so the active chunk is always
  // the low CHUNK_W bits; on the last chunk its top bit is the operand MSB.
  assign w_accept     = (r_state == S_IDLE) && in_valid && !flush;
  assign w_last       = (r_cnt == C_LAST);
  assign w_sum        = {1'b0, r_a[CHUNK_W-1:0]} + {1'b0, ~r_b[CHUNK_W-1:0]}
                      + {{CHUNK_W{1'b0}}, r_carry_acc};
  assign w_chunk_zero = (w_sum[CHUNK_W-1:0] == '0);
  assign w_sign       = w_sum[CHUNK_W-1];
  assign w_ovf        = (r_a[CHUNK_W-1] != r_b[CHUNK_W-1]) && (w_sign != r_a[CHUNK_W-1]);

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_IDLE:  if (w_accept)  w_state_nxt = S_CALC;
      S_CALC:  if (w_last)    w_state_nxt = S_DONE;
      S_DONE:  if (out_ready) w_state_nxt = S_IDLE;
      default:                w_state_nxt = S_IDLE;
    endcase
    if (flush) w_state_nxt = S_IDLE;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) r_state <= S_IDLE;
    else        r_state <= w_state_nxt;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_a         <= '0;
      r_b         <= '0;
      r_cnt       <= '0;
      r_carry_acc <= 1'b0;
      r_zero_acc  <= 1'b0;
      r_zero      <= 1'b0;
      r_carry     <= 1'b0;
      r_ovf       <= 1'b0;
      r_sign      <= 1'b0;
      r_funct3    <= 3'b000;
    end else if (w_accept) begin
      r_a         <= operand_a;
      r_b         <= operand_b;
      r_funct3    <= funct3_in;
      r_carry_acc <= 1'b1;
      r_zero_acc  <= 1'b1;
      r_cnt       <= '0;
    end else if (r_state == S_CALC && !flush) begin
      r_a         <= r_a >> CHUNK_W;
      r_b         <= r_b >> CHUNK_W;
      r_carry_acc <= w_sum[CHUNK_W];
      r_zero_acc  <= r_zero_acc & w_chunk_zero;
      r_cnt       <= r_cnt + CNT_W'(1);
      // Published flags only change on completion so they survive aborts.
      if (w_last) begin
        r_zero  <= r_zero_acc & w_chunk_zero;
        r_carry <= w_sum[CHUNK_W];
        r_sign  <= w_sign;
        r_ovf   <= w_ovf;
      end
    end
  end

  assign in_ready      = rst_n && (r_state == S_IDLE);
  assign out_valid     = (r_state == S_DONE);
  assign zero_flag     = r_zero;
  assign carry_flag    = r_carry;
  assign overflow_flag = r_ovf;
  assign sign_flag     = r_sign;
  assign funct3_out    = r_funct3;

endmodule
`default_nettype wire
